// File: rtl/muldiv_sequencer.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and divider (non-restoring).
// One iteration per cycle; MUL and non-zero DIV take 34 edges from accept to done.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rA,
  input  logic [31:0] rB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] booth_q, booth_d;
  logic [33:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic [63:0] mcand_ext;
  logic [31:0] a_mag, b_mag;
  logic [33:0] rem_shl, rem_nxt;
  logic [31:0] rem_fix, quo_sgn, rem_sgn;

  assign mcand_ext = {{32{a_q[31]}}, a_q};
  assign a_mag     = a_q[31] ? 32'(-a_q) : a_q;
  assign b_mag     = b_q[31] ? 32'(-b_q) : b_q;

  // Non-restoring step: subtract when the partial remainder is non-negative, else add back.
  assign rem_shl = {rem_q[32:0], quo_q[31]};
  assign rem_nxt = rem_q[33] ? (rem_shl + {2'b00, dvsr_q}) : (rem_shl - {2'b00, dvsr_q});

  // Final correction only needs the low 32 bits: the corrected remainder lies in [0, divisor).
  assign rem_fix = rem_q[31:0] + (rem_q[33] ? dvsr_q : 32'd0);
  assign rem_sgn = r_neg_q ? 32'(-rem_fix) : rem_fix;
  assign quo_sgn = q_neg_q ? 32'(-quo_q) : quo_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    booth_d    = booth_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          op_d       = op;
          a_d        = rA;
          b_d        = rB;
          div_zero_d = 1'b0;
        end
      end

      S_LOAD: begin
        cnt_d = 5'd0;
        if (!op_q) begin
          acc_d   = 64'd0;
          booth_d = {b_q, 1'b0};
          dz_d    = 1'b0;
          state_d = S_RUN;
        end else begin
          rem_d   = 34'd0;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          q_neg_d = a_q[31] ^ b_q[31];
          r_neg_d = a_q[31];
          dz_d    = (b_q == 32'd0);
          state_d = (b_q == 32'd0) ? S_FINISH : S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (!op_q) begin
          case (booth_q[1:0])
            2'b01:   acc_d = acc_q + (mcand_ext << cnt_q);
            2'b10:   acc_d = acc_q - (mcand_ext << cnt_q);
            default: acc_d = acc_q;
          endcase
          booth_d = {booth_q[32], booth_q[32:1]};
        end else begin
          rem_d = rem_nxt;
          quo_d = {quo_q[30:0], ~rem_nxt[33]};
        end
        if (cnt_q == 5'd31) state_d = S_FINISH;
      end

      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!op_q) begin
          hi_d = acc_q[63:32];
          lo_d = acc_q[31:0];
        end else if (dz_q) begin
          hi_d       = a_q;
          lo_d       = 32'hFFFF_FFFF;
          div_zero_d = 1'b1;
        end else begin
          hi_d = rem_sgn;
          lo_d = quo_sgn;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 1'b0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      acc_q      <= 64'd0;
      booth_q    <= 33'd0;
      rem_q      <= 34'd0;
      quo_q      <= 32'd0;
      dvsr_q     <= 32'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      booth_q    <= booth_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed MUL/DIV vectors with hand-computed results,
// latency, busy-ignore, back-to-back, divide-by-zero and mid-operation reset sequences.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] rA, rB;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [31:0] lat;
    logic [63:0] t_acc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rA(rA), .rB(rB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request; returns 1ns after the accepting edge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input logic [31:0] elat, input bit push);
    exp_t e;
    start = 1'b1; op = o; rA = a; rB = b;
    @(posedge clk);
    e.t_acc = $time;
    #1;
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    e.hi = eh; e.lo = el; e.dz = edz; e.lat = elat;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=1 expected busy=0 within 100 cycles");
    end
  endtask

  initial begin
    logic [31:0] last_hi, last_lo;
    checks = 0; errors = 0;
    reset = 1'b0; start = 1'b0; op = 1'b0; rA = '0; rB = '0;
    last_hi = '0; last_lo = '0;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          last_hi = '0; last_lo = '0;
        end else begin
          if (done) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("hi", {32'd0, hi}, {32'd0, e.hi});
              chk("lo", {32'd0, lo}, {32'd0, e.lo});
              chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
              chk("latency", ($time - 64'd5 - e.t_acc) / 64'd10, {32'd0, e.lat});
              chk("busy_in_done", {63'd0, busy}, 64'd0);
              last_hi = e.hi; last_lo = e.lo;
            end
          end
          if (busy) chk("hold_hi_lo", {hi, lo}, {last_hi, last_lo});
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // MUL vectors
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0, 34, 1'b1); wait_idle();

    // DIV vectors
    issue(1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, 1'b1); wait_idle();
    issue(1'b1, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 2, 1'b1); wait_idle();

    // MUL 2x3 clears div_zero; start at N+5 ignored; start in done cycle accepted.
    issue(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34, 1'b1);
    chk("dz_cleared_on_accept", {63'd0, div_zero}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 1'b1; rA = 32'd5; rB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("done_cycle", {63'd0, done}, 64'd1);
    issue(1'b0, 32'd100, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FF38, 1'b0, 34, 1'b1);
    wait_idle();
    @(posedge clk); #1;

    // Reset during RUN aborts with no done; start ignored while reset is low.
    issue(1'b0, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi_lo", {hi, lo}, 64'd0);
    chk("abort_dz", {63'd0, div_zero}, 64'd0);
    reset = 1'b1; start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_still_idle", {63'd0, busy}, 64'd0);

    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1); wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
